// File: rtl/sonic_scan_ctrl.sv
// Round-robin HC-SR04 scan engine: one sensor fires at a time, echo width is timed in us ticks.
// Build option: define NEAR_HYST_EN to give the near flags a hysteresis band of HYST_US.
module sonic_scan_ctrl #(
  parameter int unsigned N_SENSORS  = 4,
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned HOLDOFF_US = 60000,
  parameter int unsigned NEAR_US    = 2320,
  parameter int unsigned HYST_US    = 290
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [N_SENSORS-1:0]    i_echo,
  output logic [N_SENSORS-1:0]    o_trig,
  output logic [16*N_SENSORS-1:0] o_dist_us,
  output logic [N_SENSORS-1:0]    o_near,
  output logic [N_SENSORS-1:0]    o_timed_out,
  output logic                    o_stop,
  output logic                    o_res_valid,
  output logic [2:0]              o_res_idx
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_US - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_SENSORS - 1);

  // Counters are 16 bit and the sensor index is 3 bit; reject sets that cannot fit.
  if (N_SENSORS < 1 || N_SENSORS > 8 || CLK_PER_US < 1 || TRIG_US < 1 || HOLDOFF_US < 1 ||
      TIMEOUT_US > 65535 || HOLDOFF_US > 65535 || NEAR_US > 65535 || HYST_US > 65535) begin : g_bad_cfg
    $error("sonic_scan_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;

  logic [PRE_W-1:0]               r_presc;
  logic                           w_tick;
  logic [CNT_W-1:0]               r_cnt;
  logic [SEL_W-1:0]               r_sel;
  logic [SEL_W-1:0]               w_sel_inc;
  logic [SEL_W-1:0]               w_sel_nxt;

  logic [N_SENSORS-1:0]           r_echo_s1;
  logic [N_SENSORS-1:0]           r_echo_s2;
  logic [N_SENSORS-1:0]           r_echo_d;
  logic [N_SENSORS-1:0]           r_rise;
  logic [N_SENSORS-1:0]           r_fall;
  logic                           w_rise;
  logic                           w_fall;

  logic                           w_cnt_clr;
  logic                           w_cnt_inc;
  logic                           w_do_result;
  logic                           w_do_timeout;
  logic                           w_sel_adv;
  logic [N_SENSORS-1:0]           w_trig_nxt;

  logic [N_SENSORS-1:0][CNT_W-1:0] r_dist;
  logic [N_SENSORS-1:0]           r_near;
  logic [N_SENSORS-1:0]           r_timed_out;
  logic [N_SENSORS-1:0]           r_trig;
  logic                           r_stop;
  logic                           r_res_valid;
  logic [SEL_W-1:0]               r_res_idx;

  assign w_tick    = (r_presc == PRE_LAST);
  assign w_sel_inc = (r_sel == SEL_LAST) ? SEL_W'(0) : r_sel + SEL_W'(1);
  assign w_sel_nxt = w_sel_adv ? w_sel_inc : r_sel;

  // Free-running microsecond prescaler plus echo synchronisers and registered edge detect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_echo_s1 <= '0;
      r_echo_s2 <= '0;
      r_echo_d  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
    end else begin
      r_presc   <= w_tick ? PRE_W'(0) : r_presc + PRE_W'(1);
      r_echo_s1 <= i_echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_rise    <= r_echo_s2 & ~r_echo_d;
      r_fall    <= ~r_echo_s2 & r_echo_d;
    end
  end

  // Only the selected channel's edges matter; trigger follows the sensor selected next cycle.
  always_comb begin
    w_rise     = 1'b0;
    w_fall     = 1'b0;
    w_trig_nxt = '0;
    for (int i = 0; i < int'(N_SENSORS); i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_rise = r_rise[i];
        w_fall = r_fall[i];
      end
      if (w_sel_nxt == SEL_W'(i)) begin
        w_trig_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Rising edge beats a same-cycle timeout; falling edge beats a same-cycle saturation.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_enable) w_state_nxt = S_TRIG;
      S_TRIG: if (w_tick && (r_cnt == TRIG_LAST)) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_rise)                 w_state_nxt = S_MEAS;
        else if (r_cnt == TMO_CNT)  w_state_nxt = S_HOLD;
      end
      S_MEAS: if (w_fall || (r_cnt == TMO_CNT)) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_tick && (r_cnt == HOLD_LAST)) w_state_nxt = i_enable ? S_TRIG : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_do_result  = 1'b0;
    w_do_timeout = 1'b0;
    w_sel_adv    = 1'b0;
    case (r_state)
      S_IDLE: w_cnt_clr = 1'b1;
      S_TRIG: begin
        if (w_tick) begin
          if (r_cnt == TRIG_LAST) w_cnt_clr = 1'b1;
          else                    w_cnt_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_rise) begin
          w_cnt_clr = 1'b1;
        end else if (r_cnt == TMO_CNT) begin
          w_do_timeout = 1'b1;
          w_cnt_clr    = 1'b1;
        end else if (w_tick) begin
          w_cnt_inc = 1'b1;
        end
      end
      S_MEAS: begin
        if (w_fall) begin
          w_do_result = 1'b1;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == TMO_CNT) begin
          w_do_timeout = 1'b1;
          w_cnt_clr    = 1'b1;
        end else if (w_tick) begin
          w_cnt_inc = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          if (r_cnt == HOLD_LAST) begin
            w_sel_adv = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  // Slot counter never passes TIMEOUT_US in WAIT/MEAS because those states leave on equality.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_sel  <= '0;
      r_trig <= '0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_sel_adv)      r_sel <= w_sel_inc;
      r_trig <= (w_state_nxt == S_TRIG) ? w_trig_nxt : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dist      <= '0;
      r_near      <= '0;
      r_timed_out <= '0;
      r_stop      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
    end else begin
      r_stop      <= |r_near;
      r_res_valid <= w_do_result | w_do_timeout;
      if (w_do_result || w_do_timeout) r_res_idx <= r_sel;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        if (r_sel == SEL_W'(i)) begin
          if (w_do_result) begin
            r_dist[i]      <= r_cnt;
            r_timed_out[i] <= 1'b0;
`ifdef NEAR_HYST_EN
            if (32'(r_cnt) < NEAR_US)                r_near[i] <= 1'b1;
            else if (32'(r_cnt) >= NEAR_US + HYST_US) r_near[i] <= 1'b0;
`else
            r_near[i] <= (32'(r_cnt) < NEAR_US);
`endif
          end else if (w_do_timeout) begin
            r_dist[i]      <= TMO_CNT;
            r_timed_out[i] <= 1'b1;
            r_near[i]      <= 1'b0;
          end
        end
      end
    end
  end

  assign o_trig      = r_trig;
  assign o_dist_us   = r_dist;
  assign o_near      = r_near;
  assign o_timed_out = r_timed_out;
  assign o_stop      = r_stop;
  assign o_res_valid = r_res_valid;
  assign o_res_idx   = r_res_idx;

endmodule

// File: doc/sonic_scan_ctrl.md
Name: sonic_scan_ctrl

Overview:
Round-robin scheduler for up to N HC-SR04-style ultrasonic sensors sharing one measurement engine. Only one sensor fires at a time, which avoids acoustic crosstalk. For each sensor the block drives its trigger pulse, times the echo high period in microsecond ticks, handles timeout, stores a per-sensor result, and raises per-sensor near flags plus an aggregate stop. It sits between the sensor pins and the car motion logic.

Parameters:
N_SENSORS, 4, number of sensors scanned (1..8)
CLK_PER_US, 100, clk cycles per 1 µs tick (100 MHz clk)
TRIG_US, 10, trigger pulse width in µs ticks
TIMEOUT_US, 30000, max wait for echo rise and max echo width, in µs
HOLDOFF_US, 60000, quiet time after each measurement before the next sensor fires
NEAR_US, 2320, near threshold in µs (40 cm × 58 µs/cm)
HYST_US, 290, hysteresis band in µs (5 cm); used only with NEAR_HYST_EN

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = keep scanning; 0 = finish current slot, then idle
echo  in  N_SENSORS  raw echo pins, asynchronous
trig  out  N_SENSORS  trigger pins; at most one bit high at any time
dist_us  out  16*N_SENSORS  latest echo width per sensor in µs; sensor i occupies bits [16i+15:16i]
near  out  N_SENSORS  per-sensor obstacle-near flag
timed_out  out  N_SENSORS  1 = sensor's latest slot timed out
stop  out  1  OR of near
res_valid  out  1  one-cycle pulse when any result register updates
res_idx  out  3  sensor index of the current/last update

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, sel=0, tick prescaler=0, slot counter=0. All outputs 0: trig, dist_us, near, timed_out, stop, res_valid, res_idx. Echo synchronisers cleared. Reset mid-slot aborts immediately; trig drops on the next edge.
- Echo input: each bit passes a 2-flop synchroniser, then an edge detector on the synced value.
  - Only echo[sel] is observed; other channels are ignored.
  - Edge-to-state-change latency is 3 clk cycles.
- Tick: prescaler counts 0..CLK_PER_US-1 and is free-running outside reset. tick=1 for one cycle at wrap. The slot counter (16 bit) advances on tick only.
- FSM:
  - IDLE: trig=0. If enable: counter=0, go to TRIG.
  - TRIG: trig[sel]=1. On the tick where counter reaches TRIG_US-1: trig=0, counter=0, go to WAIT_ECHO.
  - WAIT_ECHO: on echo[sel] rising edge, counter=0 and go to MEASURE. Else, when counter reaches TIMEOUT_US, do a TIMEOUT update and go to HOLDOFF. A rising edge wins over a same-cycle timeout.
  - MEASURE: counter increments per tick, saturating at TIMEOUT_US.
    - On falling edge: do a RESULT update, go to HOLDOFF.
    - If counter==TIMEOUT_US with no fall: do a TIMEOUT update, go to HOLDOFF.
    - A falling edge wins over a same-cycle saturation.
  - HOLDOFF: counter restarts at 0 and counts to HOLDOFF_US-1. Then sel advances (N_SENSORS-1 wraps to 0). Go to TRIG if enable, else IDLE.
- RESULT update (registered, one cycle):
  - dist_us[sel]<=counter, timed_out[sel]<=0
  - near[sel]<=(counter<NEAR_US)
  - res_valid=1, res_idx<=sel
- TIMEOUT update:
  - dist_us[sel]<=TIMEOUT_US, timed_out[sel]<=1, near[sel]<=0
  - res_valid=1, res_idx<=sel
- stop is registered OR of near, so it lags near by 1 cycle.
- If enable falls mid-slot, the slot completes including holdoff, sel advances, and the FSM stays in IDLE. Results are retained while idle.
- Echo already high at TRIG end: no rising edge is seen, so WAIT_ECHO times out.
- Width rules: TIMEOUT_US and HOLDOFF_US must be ≤65535. Comparisons are unsigned.

Optional Feature:
NEAR_HYST_EN — when defined, near has hysteresis. On a RESULT update:
- near[sel] sets if counter<NEAR_US.
- near[sel] clears if counter≥NEAR_US+HYST_US.
- Otherwise near[sel] holds its value.
A TIMEOUT update always clears near. When not defined, near is the plain compare and HYST_US is unused.

Test Plan:
- Bench overrides CLK_PER_US=2, HOLDOFF_US=50, TIMEOUT_US=3000. Reset then enable=1 -> trig[0] high for exactly 20 clk; trig[1..3] stay 0.
- Echo[0] high for 1160 µs -> dist_us[0]=1160±1, near[0]=1, stop=1, one res_valid pulse with res_idx=0; then trig[1] fires after holdoff.
- No echo on sensor 1 -> after 3000 µs: timed_out[1]=1, dist_us[1]=3000, near[1]=0; scan continues to sensor 2.
- Echo[2] held high 4000 µs -> saturates; timed_out[2]=1, dist_us[2]=3000. Echo[3] toggling during sensor 2's slot -> no effect.
- enable=0 while in MEASURE on sensor 3 -> result still stored, sel wraps to 0, FSM idles with trig=0. Assert rst mid-TRIG -> all outputs 0 next cycle.
- With NEAR_HYST_EN: widths 2000, 2400, 2700 on one sensor -> near = 1, 1, 0. Without the macro -> near = 1, 0, 0.
